pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined ripple-carry adder: successor to the single-bit full adder.
- Splits a WIDTH-bit addition (a + b + cin) into STAGES equal slices, one slice per clock stage; the carry propagates registered between stages.
- Valid/ready handshake on input and output with full-pipeline stall, so it can sit directly in a streaming datapath.
- Intended as the common adder primitive for wider arithmetic units in this codebase.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry in.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- carry  output  1  carry out of the MSB.

Interface decision: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Global advance: adv = !out_valid || out_ready. in_ready = adv. It is combinational from out_ready and is the only comb path.
- Accept: an input beat is taken when in_valid && in_ready.
- Stage k (0..STAGES-1): computes slice k, bits [k*SW +: SW], plus the registered carry from stage k-1. Stage 0 uses cin.
  - Each slice bit is sum = a^b^c, carry = (a^b)&c | a&b.
- Skew registers: carry the upper, not-yet-added operand slices forward. Lower sum slices are held in de-skew registers so the full sum emerges aligned.
- Per-stage valid bit shifts on adv. out_valid = valid of the last stage.
- Latency: exactly STAGES cycles from acceptance to out_valid when not stalled. Throughput is one beat per cycle.
- Stall: when adv=0, every pipeline register holds, including valid bits. sum, carry and out_valid stay stable until out_ready.
- Bubbles: invalid stages still shift on adv. Data in bubbles is don't-care, but out_valid must be 0 for them.
- Overflow wrap: the sum wraps modulo 2^WIDTH; carry=1 exactly when the true result is >= 2^WIDTH.
- Simultaneous out-accept and in-accept while the pipe is full: both happen in the same cycle with no bubble inserted.
- Reset (rst_n=0 at a clock edge):
  - All valid bits clear, and sum, carry and out_valid go to 0. Data registers may also be cleared.
  - in_ready=1 in the first cycle after reset release.
  - Beats in flight at reset are dropped silently. Inputs are ignored while rst_n=0.
- STAGES=1: the block degenerates to a registered WIDTH-bit adder with latency 1.

Optional Feature:
- Macro: PIPELINED_ADDER_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), the signed two's-complement overflow: carry into MSB XOR carry out of MSB.
  - It is registered and aligned with sum, and resets to 0.
- When undefined: the port and its logic are absent; everything else is unchanged.

Decomposition:
- Shared package/include file:
  - Slice-width function.
  - Localparam check macro for WIDTH % STAGES == 0 (elaboration error otherwise).
  - Handshake-advance helper constant names used across the arithmetic blocks.
- One sub-module, adder_slice: a combinational SW-bit ripple slice built from per-bit full-adder equations.
  - Ports: a, b, cin, sum, carry (plus msb carry-in when overflow is enabled).
  - pipelined_adder instantiates STAGES of them and owns all registers and the handshake.

Test Plan (WIDTH=8, STAGES=2 unless stated):
- Basic: a=8'h35, b=8'h4A, cin=0, out_ready=1 -> out_valid 2 cycles later with sum=8'h7F, carry=0.
- Cross-slice carry: a=8'h0F, b=8'h01, cin=0 -> sum=8'h10, carry=0. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1.
- Streaming: 16 back-to-back random beats with out_ready=1 -> results in order, one per cycle, in_ready constantly 1. Compare against a reference model.
- Backpressure:
  - Fill the pipe, then hold out_ready=0 for 5 cycles -> in_ready=0, and sum/carry/out_valid are stable.
  - Release -> no beats lost or duplicated.
- Reset mid-flight: 2 beats accepted, then rst_n=0 for one edge -> out_valid=0, sum=0, carry=0. No stale beat emerges afterwards.
- With PIPELINED_ADDER_OVERFLOW_EN and STAGES=1:
  - 8'h7F + 8'h01 -> sum=8'h80, overflow=1, carry=0.
  - 8'hFF + 8'h01 -> sum=8'h00, carry=1, overflow=0.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder family: slice sizing,
// parameter legality check, bus offset helpers and handshake advance.
package pipelined_adder_pkg;

    // Names for the two states of the global pipeline advance enable.
    localparam logic ADV_HOLD  = 1'b0;
    localparam logic ADV_SHIFT = 1'b1;

    // Width of one pipeline slice.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal parameter combination: 1..WIDTH stages dividing WIDTH evenly.
    function automatic bit slices_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Stage k still has (width - k*sw) operand bits to consume. These
    // remaining-operand fields are packed back to back in one bus; this
    // returns the offset of stage k's field (k = stages gives total width).
    function automatic int rem_off(input int k, input int width, input int sw);
        return k * width - (sw * k * (k - 1)) / 2;
    endfunction

    // Stage k produces (k+1)*sw aligned sum bits. Offset of stage k's field
    // in the packed partial-sum bus (k = stages gives total width).
    function automatic int psum_off(input int k, input int sw);
        return (sw * k * (k + 1)) / 2;
    endfunction

    // The whole pipe shifts unless a valid result is blocked downstream.
    function automatic logic advance(input logic out_valid, input logic out_ready);
        return (!out_valid || out_ready) ? ADV_SHIFT : ADV_HOLD;
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry slice built from per-bit full adders.
// With PIPELINED_ADDER_OVERFLOW_EN defined it also exposes the carry into
// its most significant bit, for signed-overflow detection.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic          cmsb
`endif
);

    logic [SW-1:0] c_bit;

    // Ripple the carry through the slice, recording the carry into each bit.
    always_comb begin : ripple
        logic c;
        c_bit = '0;
        c     = cin;
        for (int i = 0; i < SW; i++) begin
            c_bit[i] = c;
            c        = ((a[i] ^ b[i]) & c) | (a[i] & b[i]);
        end
        carry = c;
    end

    assign sum = a ^ b ^ c_bit;

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign cmsb = c_bit[SW-1];
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES slices, one
// slice added per clock with the carry registered between stages. Upper
// operand slices ride forward in skew registers, finished lower sum slices
// ride forward in de-skew registers so the full sum emerges aligned.
// Valid/ready handshake with whole-pipe stall; synchronous active-low reset.
// Optional macro PIPELINED_ADDER_OVERFLOW_EN adds the registered signed
// overflow output.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int SW      = slice_width(WIDTH, STAGES);
    localparam int REM_W   = rem_off(STAGES, WIDTH, SW);
    localparam int PSUM_W  = psum_off(STAGES, SW);
    localparam int LAST_PO = psum_off(STAGES - 1, SW);

    if (!slices_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic              adv;
    logic [REM_W-1:0]  rem_a;
    logic [REM_W-1:0]  rem_b;
    logic [PSUM_W-1:0] psum;
    logic [STAGES-1:0] stg_cin;
    logic [STAGES-1:0] stg_cout;
    logic [STAGES-1:0] stg_valid;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic [STAGES-1:0] stg_cmsb;
    logic              overflow_q;
    logic              overflow_d;
`endif

    logic [WIDTH-1:0]  sum_q;
    logic [WIDTH-1:0]  sum_d;
    logic              carry_q;
    logic              carry_d;
    logic              out_valid_q;
    logic              out_valid_d;

    assign adv      = advance(out_valid_q, out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * SW;
        localparam int RO = rem_off(k, WIDTH, SW);
        localparam int PW = (k + 1) * SW;
        localparam int PO = psum_off(k, SW);

        logic [SW-1:0] sl_sum;

        if (k == 0) begin : g_head
            // Stage 0 adds straight from the input operands.
            assign rem_a[RO +: RW] = a;
            assign rem_b[RO +: RW] = b;
            assign stg_cin[k]      = cin;
            assign stg_valid[k]    = in_valid;
            assign psum[PO +: PW]  = sl_sum;
        end else begin : g_body
            localparam int PRO = rem_off(k - 1, WIDTH, SW);
            localparam int PPO = psum_off(k - 1, SW);

            logic [RW-1:0]   a_q;
            logic [RW-1:0]   b_q;
            logic            c_q;
            logic            v_q;
            logic [k*SW-1:0] psum_q;

            // Capture the not-yet-added operand bits, the carry and the lower sum.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q    <= '0;
                    b_q    <= '0;
                    c_q    <= 1'b0;
                    v_q    <= 1'b0;
                    psum_q <= '0;
                end else if (adv) begin
                    a_q    <= rem_a[PRO + SW +: RW];
                    b_q    <= rem_b[PRO + SW +: RW];
                    c_q    <= stg_cout[k-1];
                    v_q    <= stg_valid[k-1];
                    psum_q <= psum[PPO +: k*SW];
                end
            end

            assign rem_a[RO +: RW] = a_q;
            assign rem_b[RO +: RW] = b_q;
            assign stg_cin[k]      = c_q;
            assign stg_valid[k]    = v_q;
            assign psum[PO +: PW]  = {sl_sum, psum_q};
        end

        adder_slice #(
            .SW (SW)
        ) u_slice (
            .a     (rem_a[RO +: SW]),
            .b     (rem_b[RO +: SW]),
            .cin   (stg_cin[k]),
            .sum   (sl_sum),
            .carry (stg_cout[k])
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            ,
            .cmsb  (stg_cmsb[k])
`endif
        );
    end

    assign sum_d       = psum[LAST_PO +: WIDTH];
    assign carry_d     = stg_cout[STAGES-1];
    assign out_valid_d = stg_valid[STAGES-1];
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow_d  = stg_cmsb[STAGES-1] ^ stg_cout[STAGES-1];
`endif

    // Output register: the final slice result, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            overflow_q  <= 1'b0;
`endif
        end else if (adv) begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=8; STAGES=2, or STAGES=1
// when PIPELINED_ADDER_OVERFLOW_EN is defined).
`timescale 1ns/1ps
module tb_pipelined_adder;

    localparam int WIDTH = 8;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    localparam int STAGES = 1;
`else
    localparam int STAGES = 2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf_obs;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic             overflow;
    assign ovf_obs = overflow;
`else
    assign ovf_obs = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    typedef struct packed {
        logic             ovf;
        logic             carry;
        logic [WIDTH-1:0] sum;
    } res_t;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        res_t r;
        int total, sx, sy, st;
        total   = int'(x) + int'(y) + int'(ci);
        r.sum   = WIDTH'(total % (1 << WIDTH));
        r.carry = (total >= (1 << WIDTH));
        sx      = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy      = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        st      = sx + sy + int'(ci);
        r.ovf   = (st > (1 << (WIDTH - 1)) - 1) || (st < -(1 << (WIDTH - 1)));
        return r;
    endfunction

    // Send one beat into an idle pipe and return the result and its latency.
    task automatic send_one(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic ci, output res_t got, output int lat);
        a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got = {ovf_obs, carry, sum};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
        checks++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", carry); end
        checks++; if (ovf_obs !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", ovf_obs); end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        begin
            bit seen = 1'b0;
            for (int i = 0; i < STAGES + 2; i++) begin
                @(negedge clk);
                seen |= out_valid;
            end
            @(posedge clk); #1;
            checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_ignored_input: got out_valid=%b want 0", seen); end
        end
    endtask

    task automatic test_basic();
        res_t got; int lat;
        send_one(8'h35, 8'h4A, 1'b0, got, lat);
        checks++; if (lat !== STAGES) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, STAGES); end
        checks++; if (got.sum !== 8'h7F) begin errors++; $display("FAIL basic_sum: got %h want 7f", got.sum); end
        checks++; if (got.carry !== 1'b0) begin errors++; $display("FAIL basic_carry: got %b want 0", got.carry); end
    endtask

    task automatic test_cross_slice();
        res_t got; int lat;
        send_one(8'h0F, 8'h01, 1'b0, got, lat);
        checks++; if ({got.carry, got.sum} !== 9'h010) begin errors++; $display("FAIL cross_0f_01: got c=%b s=%h want c=0 s=10", got.carry, got.sum); end
        send_one(8'hFF, 8'h00, 1'b1, got, lat);
        checks++; if ({got.carry, got.sum} !== 9'h100) begin errors++; $display("FAIL cross_ff_00_c1: got c=%b s=%h want c=1 s=00", got.carry, got.sum); end
        checks++; if (lat !== STAGES) begin errors++; $display("FAIL cross_latency: got %0d want %0d", lat, STAGES); end
    endtask

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        res_t got; int lat;
        send_one(8'h7F, 8'h01, 1'b0, got, lat);
        checks++; if (got !== {1'b1, 1'b0, 8'h80}) begin errors++; $display("FAIL ovf_7f_01: got o=%b c=%b s=%h want o=1 c=0 s=80", got.ovf, got.carry, got.sum); end
        send_one(8'hFF, 8'h01, 1'b0, got, lat);
        checks++; if (got !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL ovf_ff_01: got o=%b c=%b s=%h want o=0 c=1 s=00", got.ovf, got.carry, got.sum); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency: got %0d want 1", lat); end
    endtask
`endif

    task automatic test_back_to_back();
        res_t exp_q[$];
        res_t e;
        int sent = 0, recv = 0, first = -1, last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 16 + STAGES + 4; cyc++) begin
            if (sent < 16) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: cycle %0d got %b want 1", cyc, in_ready); end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stream_extra_beat: got s=%h want no beat", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({carry, sum} !== {e.carry, e.sum}) begin
                        errors++; $display("FAIL stream_result: beat %0d got c=%b s=%h want c=%b s=%h", recv, carry, sum, e.carry, e.sum);
                    end
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    checks++;
                    if (ovf_obs !== e.ovf) begin errors++; $display("FAIL stream_overflow: beat %0d got %b want %b", recv, ovf_obs, e.ovf); end
`endif
                end
                recv++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++; if (recv !== 16) begin errors++; $display("FAIL stream_count: got %0d want 16", recv); end
        checks++; if (first !== STAGES) begin errors++; $display("FAIL stream_first_cycle: got %0d want %0d", first, STAGES); end
        checks++; if (last - first !== 15) begin errors++; $display("FAIL stream_gapless: got span %0d want 15", last - first); end
    endtask

    task automatic test_backpressure();
        res_t exp_q[$];
        res_t e;
        int sent = 0, recv = 0, stall_obs = 0;
        logic [WIDTH+1:0] held = '0;
        out_ready = 1'b0; in_valid = 1'b1;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        for (int cyc = 0; cyc < 60; cyc++) begin
            bit took;
            @(negedge clk);
            if (out_valid && !out_ready) begin
                if (stall_obs == 0) begin
                    held = {out_valid, carry, sum};
                end else begin
                    checks++; if ({out_valid, carry, sum} !== held) begin errors++; $display("FAIL stall_stable: got %h want %h", {out_valid, carry, sum}, held); end
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
                end
                stall_obs++;
            end
            took = in_valid && in_ready;
            if (took) begin
                exp_q.push_back(model(a, b, cin));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat: got s=%h want no beat", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({carry, sum} !== {e.carry, e.sum}) begin
                        errors++; $display("FAIL bp_result: beat %0d got c=%b s=%h want c=%b s=%h", recv, carry, sum, e.carry, e.sum);
                    end
                end
                recv++;
            end
            @(posedge clk); #1;
            out_ready = (stall_obs >= 6);
            if (took) begin
                if (sent < 12) begin
                    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (stall_obs !== 6) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 6", stall_obs); end
        checks++; if (sent !== 12 || recv !== 12) begin errors++; $display("FAIL bp_count: got sent=%0d recv=%0d want 12/12", sent, recv); end
    endtask

    task automatic test_reset_midflight();
        bit seen = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1;
        a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'hF0; b = 8'h0F; cin = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0; a = 8'h77; b = 8'h11;
        @(posedge clk); #1;
        checks++; if ({out_valid, carry, sum} !== '0) begin errors++; $display("FAIL midreset_clear: got v=%b c=%b s=%h want 0/0/00", out_valid, carry, sum); end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 2 * STAGES + 3; i++) begin
            @(negedge clk);
            seen |= out_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_stale: got out_valid=%b want 0", seen); end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_cross_slice();
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
